dcache_uncache_ctrl: RTL and testbench
======================================

# dcache_uncache_ctrl

Sequencer for uncached data-side accesses in the NPC data cache. Accepts one load/store at a time from the dcache front end, confirms it lies in an uncached window (device/MMIO space) and performs exactly one single-beat AXI4-Lite-style read or write on the memory bus. It then returns data and an error flag to the requester. It sits beside the cacheable refill/writeback path and owns the bus only while an uncached access is in flight.

## Interface
- `ADDR_W`, 32: bus address width
- `DATA_W`, `XLEN` (64): data width
- `TO_CYC`, 255: timeout limit in cycles (used only with timeout compiled in)

Ports:
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `req_valid_i` in 1: request present
- `req_ready_o` out 1: controller idle, can accept
- `req_we_i` in 1: 1 = store, 0 = load
- `req_addr_i` in ADDR_W: byte address
- `req_size_i` in 3: AXI size code (0 = 1B … 3 = 8B)
- `req_wdata_i` in DATA_W: store data, lane-aligned
- `req_wstrb_i` in DATA_W/8: byte strobes
- `resp_valid_o` out 1: one-cycle response pulse
- `resp_rdata_o` out DATA_W: raw read beat
- `resp_err_o` out 1: bus error, window violation or timeout
- Bus read channels: `ar_valid_o`/`ar_ready_i`/`ar_addr_o`[ADDR_W]/`ar_size_o`[3]; `r_valid_i`/`r_ready_o`/`r_data_i`[DATA_W]/`r_resp_i`[2]
- Bus write channels: `aw_valid_o`/`aw_ready_i`/`aw_addr_o`/`aw_size_o`; `w_valid_o`/`w_ready_i`/`w_data_o`/`w_strb_o`; `b_valid_i`/`b_ready_o`/`b_resp_i`[2]

## Operation
- States: IDLE, CHK, AR, R, AWW, B, RESP.
- IDLE: `req_ready_o`=1. On `req_valid_i`&&`req_ready_o`, register we/addr/size/wdata/wstrb and go to CHK.
- CHK: the registered address is tested against the uncached windows 0x0F00_0000–0x0FFF_FFFF, 0x1000_0000–0x1000_0FFF and 0xA000_0000–0xBFFF_FFFF, inclusive, on the low 32 bits.
  - Outside all windows: go to RESP with err=1 and rdata=0, with no bus activity.
  - Inside a window: go to AR if load, AWW if store.
- AR: `ar_valid_o`=1, holding addr/size stable until `ar_ready_i`, then go to R.
- R: `r_ready_o`=1. On `r_valid_i`, capture `r_data_i` and err=(`r_resp_i`!=0), then go to RESP.
- AWW: `aw_valid_o` and `w_valid_o` rise together. Each drops independently after its own handshake; two sticky done bits track this. When both are done (same or different cycles) go to B.
- B: `b_ready_o`=1. On `b_valid_i`, err=(`b_resp_i`!=0) and rdata=0, then go to RESP.
- RESP: `resp_valid_o`=1 for exactly one cycle (no back-pressure), then go to IDLE.
- Only one access is in flight. No new request is accepted before RESP completes.

## Timing
- Reset: state=IDLE, `req_ready_o`=1. All valid/ready outputs, `resp_valid_o` and `resp_err_o` are 0. `resp_rdata_o` is 0. Address/data outputs are 0.
- Reset mid-transaction: aborts to IDLE next edge. Any bus transaction in progress is abandoned.
- Minimum load latency, with ready/valid both immediate, from the accept edge: CHK +1, AR +2, R +3, `resp_valid_o` high in cycle 4.
- Minimum store latency: the same, 4 cycles.
- Window violation: `resp_valid_o` in cycle 2.
- Bus outputs are registered, with no combinational paths from bus inputs to bus outputs.
- `resp_rdata_o`/`resp_err_o` hold their value after RESP until the next RESP.

## Configuration
- `DCACHE_UNCACHE_TIMEOUT_EN` defined:
  - An 8-bit-min counter of width $clog2(TO_CYC+1) clears on entering AR or AWW and increments every cycle in AR/R/AWW/B.
  - When it reaches `TO_CYC`, all bus valid/ready outputs drop and the controller goes to RESP with err=1 and rdata=0.
  - A handshake in the same cycle as expiry takes priority over the timeout.
- Undefined: no counter, and the controller waits indefinitely for the bus.

## Structure
- Shared package/header `sysconfig.v` supplies `XLEN`. State encodings are local parameters.
- Window decode reuses the existing `dcache_uncache_check` module, instantiated once on the registered address. No other sub-module.

## Test plan
- Load 0xA000_0048, size 3, zero-wait bus, r_data=0x1122_3344_5566_7788, rresp=0 → ar_addr=0xA000_0048, resp_valid in cycle 4, rdata=0x1122334455667788, err=0.
- Store 0x1000_0004, wstrb=0x0F, aw_ready 3 cycles before w_ready, bresp=0 → aw and w each drop on their own handshake, single B, resp err=0, rdata=0.
- Load 0x8000_0000 → no ar_valid ever, resp_valid in cycle 2, err=1.
- Load 0x0F00_0000 with rresp=2 (SLVERR), plus boundary address 0x1000_0FFF (in) and 0x1000_1000 (out) → first two reach the bus (SLVERR case gives err=1), last returns err=1 without bus activity.
- `rst` asserted during R with r_valid withheld → next cycle IDLE, req_ready=1, r_ready=0, no resp_valid.
- With `DCACHE_UNCACHE_TIMEOUT_EN`, TO_CYC=16, ar_ready held 0 → ar_valid drops after 16 cycles, resp err=1. Without the macro, the controller is still in AR after 1000 cycles.

Source files
------------

// File: rtl/dcache_uncache_ctrl_pkg.sv
// Shared definitions for the uncached data-side access sequencer:
// the data width and the controller state encoding.
package dcache_uncache_ctrl_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dcache_uncache_ctrl_check.sv
// Uncached window decode. The address is in device/MMIO space when it falls
// in one of these inclusive ranges:
//   0x0F00_0000 - 0x0FFF_FFFF
//   0x1000_0000 - 0x1000_0FFF
//   0xA000_0000 - 0xBFFF_FFFF
module dcache_uncache_ctrl_check (
  input  logic [31:0] addr,
  output logic        hit
);

  logic win_dev;
  logic win_mmio;
  logic win_kseg;

  assign win_dev  = (addr[31:24] == 8'h0F);
  assign win_mmio = (addr[31:12] == 20'h10000);
  assign win_kseg = (addr[31:29] == 3'b101);
  assign hit      = win_dev | win_mmio | win_kseg;

endmodule

// File: rtl/dcache_uncache_ctrl.sv
// Uncached load/store sequencer. It takes one request at a time, checks that
// the address lies in an uncached window, and then performs a single-beat
// read or write on the memory bus. The result goes back to the requester as a
// one-cycle response pulse.
// Optional bus timeout: define DCACHE_UNCACHE_TIMEOUT_EN.
module dcache_uncache_ctrl
  import dcache_uncache_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = XLEN,
  parameter int TO_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [2:0]            req_size_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_wstrb_i,
  output logic                  resp_valid_o,
  output logic [DATA_W-1:0]     resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [ADDR_W-1:0]     ar_addr_o,
  output logic [2:0]            ar_size_o,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [DATA_W-1:0]     r_data_i,
  input  logic [1:0]            r_resp_i,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  output logic [ADDR_W-1:0]     aw_addr_o,
  output logic [2:0]            aw_size_o,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic [DATA_W-1:0]     w_data_o,
  output logic [DATA_W/8-1:0]   w_strb_o,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [1:0]            b_resp_i
);

  state_t                state_q, state_d;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2:0]            size_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  aw_done_q, w_done_q;
  logic [DATA_W-1:0]     resp_rdata_q;
  logic                  resp_err_q;
  logic                  resp_load;
  logic [DATA_W-1:0]     rdata_d;
  logic                  err_d;
  logic                  in_window;
  logic                  timeout;
  logic                  aw_fin, w_fin;

  dcache_uncache_ctrl_check u_check (
    .addr (addr_q[31:0]),
    .hit  (in_window)
  );

`ifdef DCACHE_UNCACHE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TO_CYC - 1);

  logic [CNT_W-1:0] to_cnt_q;

  // Bus wait counter: restarts as the bus phase begins and ticks while waiting on the bus.
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_CHK) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_AR || state_q == ST_R ||
                 state_q == ST_AWW || state_q == ST_B) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout = (to_cnt_q == TO_LIM);
`else
  logic unused_to_cfg;
  assign unused_to_cfg = (TO_CYC == 0);
  assign timeout       = 1'b0;
`endif

  // A write address/data phase is finished when it completed earlier or completes now.
  assign aw_fin = aw_done_q | aw_ready_i;
  assign w_fin  = w_done_q  | w_ready_i;

  // State register, the captured request, and the held response values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        size_q  <= req_size_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
      end
      if (resp_load) begin
        resp_rdata_q <= rdata_d;
        resp_err_q   <= err_d;
      end
    end
  end

  // Sticky handshake flags so that AW and W can each complete in a different cycle.
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_CHK) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q == ST_AWW) begin
      if (!aw_done_q && aw_ready_i) aw_done_q <= 1'b1;
      if (!w_done_q && w_ready_i)   w_done_q  <= 1'b1;
    end
  end

  // Next-state and output decode. Handshakes take priority over timeout.
  always_comb begin
    state_d      = state_q;
    resp_load    = 1'b0;
    rdata_d      = '0;
    err_d        = 1'b0;
    req_ready_o  = 1'b0;
    ar_valid_o   = 1'b0;
    r_ready_o    = 1'b0;
    aw_valid_o   = 1'b0;
    w_valid_o    = 1'b0;
    b_ready_o    = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ST_CHK;
      end
      ST_CHK: begin
        if (!in_window) begin
          state_d   = ST_RESP;
          resp_load = 1'b1;
          err_d     = 1'b1;
        end else begin
          state_d = we_q ? ST_AWW : ST_AR;
        end
      end
      ST_AR: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) begin
          state_d = ST_R;
        end else if (timeout) begin
          state_d   = ST_RESP;
          resp_load = 1'b1;
          err_d     = 1'b1;
        end
      end
      ST_R: begin
        r_ready_o = 1'b1;
        if (r_valid_i) begin
          state_d   = ST_RESP;
          resp_load = 1'b1;
          rdata_d   = r_data_i;
          err_d     = (r_resp_i != 2'b00);
        end else if (timeout) begin
          state_d   = ST_RESP;
          resp_load = 1'b1;
          err_d     = 1'b1;
        end
      end
      ST_AWW: begin
        aw_valid_o = !aw_done_q;
        w_valid_o  = !w_done_q;
        if (aw_fin && w_fin) begin
          state_d = ST_B;
        end else if (timeout) begin
          state_d   = ST_RESP;
          resp_load = 1'b1;
          err_d     = 1'b1;
        end
      end
      ST_B: begin
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          state_d   = ST_RESP;
          resp_load = 1'b1;
          err_d     = (b_resp_i != 2'b00);
        end else if (timeout) begin
          state_d   = ST_RESP;
          resp_load = 1'b1;
          err_d     = 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ar_addr_o    = addr_q;
  assign ar_size_o    = size_q;
  assign aw_addr_o    = addr_q;
  assign aw_size_o    = size_q;
  assign w_data_o     = wdata_q;
  assign w_strb_o     = wstrb_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_dcache_uncache_ctrl.sv
// Directed bench for the uncached access sequencer. Bus responses are driven
// by hand, and outputs are sampled on the falling edge.
module tb_dcache_uncache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [63:0] r_data = '0;
  logic [1:0]  r_resp = '0;
  logic        aw_valid;
  logic        aw_ready = 1'b0;
  logic [31:0] aw_addr;
  logic [2:0]  aw_size;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [1:0]  b_resp = '0;

  int errors = 0;
  int checks = 0;

  dcache_uncache_ctrl #(.ADDR_W(32), .DATA_W(64), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_size_o(ar_size),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_size_o(aw_size),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(negedge clk);
  endtask

  // Present a request for one cycle. It is accepted on the following rising edge.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [2:0] size,
                                input logic [63:0] wdata, input logic [7:0] wstrb);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Directed scenario sequence.
  initial begin
    int ar_cnt;
    int resp_seen;
    int err_seen;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_handshakes", {ar_valid, r_ready, aw_valid, w_valid, b_ready, resp_valid, resp_err}, 0);
    check_output("rst_rdata", resp_rdata, 0);
    check_output("rst_addr", {ar_addr, aw_addr}, 0);
    check_output("rst_wdata", w_data, 0);

    // Zero-wait load from 0xA000_0048.
    ar_ready = 1'b1; r_valid = 1'b1; r_data = 64'h1122_3344_5566_7788; r_resp = 2'd0;
    apply_stimulus(1'b0, 32'hA000_0048, 3'd3, 64'd0, 8'd0);
    next_cycle;
    check_output("ld_c1_ar_valid", ar_valid, 0);
    next_cycle;
    check_output("ld_c2_ar_valid", ar_valid, 1);
    check_output("ld_c2_ar_addr", ar_addr, 64'hA000_0048);
    check_output("ld_c2_ar_size", ar_size, 3);
    next_cycle;
    check_output("ld_c3_r_ready", r_ready, 1);
    check_output("ld_c3_resp_valid", resp_valid, 0);
    next_cycle;
    check_output("ld_c4_resp_valid", resp_valid, 1);
    check_output("ld_c4_rdata", resp_rdata, 64'h1122_3344_5566_7788);
    check_output("ld_c4_err", resp_err, 0);
    next_cycle;
    check_output("ld_c5_resp_valid", resp_valid, 0);
    check_output("ld_c5_req_ready", req_ready, 1);
    check_output("ld_c5_rdata_hold", resp_rdata, 64'h1122_3344_5566_7788);
    r_valid = 1'b0; ar_ready = 1'b0;

    // Load outside every window.
    apply_stimulus(1'b0, 32'h8000_0000, 3'd3, 64'd0, 8'd0);
    next_cycle;
    check_output("viol_c1", {ar_valid, resp_valid}, 0);
    next_cycle;
    check_output("viol_c2_resp_valid", resp_valid, 1);
    check_output("viol_c2_err", resp_err, 1);
    check_output("viol_c2_rdata", resp_rdata, 0);
    check_output("viol_c2_ar_valid", ar_valid, 0);
    next_cycle;
    check_output("viol_c3_resp_valid", resp_valid, 0);

    // Store where AW completes three cycles before W.
    aw_ready = 1'b1; w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'd0;
    apply_stimulus(1'b1, 32'h1000_0004, 3'd2, 64'h0000_0000_CAFE_F00D, 8'h0F);
    next_cycle;
    check_output("st_c1_valids", {aw_valid, w_valid}, 0);
    next_cycle;
    check_output("st_c2_valids", {aw_valid, w_valid}, 2'b11);
    check_output("st_c2_aw_addr", aw_addr, 64'h1000_0004);
    check_output("st_c2_w_data", w_data, 64'h0000_0000_CAFE_F00D);
    check_output("st_c2_w_strb", w_strb, 8'h0F);
    next_cycle;
    check_output("st_c3_valids", {aw_valid, w_valid}, 2'b01);
    next_cycle;
    check_output("st_c4_valids", {aw_valid, w_valid}, 2'b01);
    next_cycle;
    w_ready = 1'b1;
    check_output("st_c5_w_b", {w_valid, b_ready}, 2'b10);
    next_cycle;
    check_output("st_c6_w_b", {aw_valid, w_valid, b_ready}, 3'b001);
    next_cycle;
    check_output("st_c7_resp_valid", resp_valid, 1);
    check_output("st_c7_err", resp_err, 0);
    check_output("st_c7_rdata", resp_rdata, 0);
    check_output("st_c7_b_ready", b_ready, 0);
    next_cycle;
    check_output("st_c8_resp_valid", resp_valid, 0);
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;

    // Load with an SLVERR response.
    ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'd2; r_data = 64'hDEAD_BEEF_0000_0001;
    apply_stimulus(1'b0, 32'h0F00_0000, 3'd2, 64'd0, 8'd0);
    next_cycle;
    next_cycle;
    check_output("slv_c2_ar_valid", ar_valid, 1);
    next_cycle;
    next_cycle;
    check_output("slv_c4_resp_valid", resp_valid, 1);
    check_output("slv_c4_err", resp_err, 1);
    check_output("slv_c4_rdata", resp_rdata, 64'hDEAD_BEEF_0000_0001);
    next_cycle;

    // Last byte of the MMIO window.
    r_resp = 2'd0; r_data = 64'h0123_4567_89AB_CDEF;
    apply_stimulus(1'b0, 32'h1000_0FFF, 3'd0, 64'd0, 8'd0);
    next_cycle;
    next_cycle;
    check_output("bin_c2_ar_valid", ar_valid, 1);
    check_output("bin_c2_ar_addr", ar_addr, 64'h1000_0FFF);
    next_cycle;
    next_cycle;
    check_output("bin_c4_resp", {resp_valid, resp_err}, 2'b10);
    check_output("bin_c4_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
    next_cycle;

    // First byte past the MMIO window.
    apply_stimulus(1'b0, 32'h1000_1000, 3'd0, 64'd0, 8'd0);
    next_cycle;
    next_cycle;
    check_output("bout_c2_resp", {resp_valid, resp_err}, 2'b11);
    check_output("bout_c2_ar_valid", ar_valid, 0);
    next_cycle;
    r_valid = 1'b0;

    // Reset while waiting in R.
    apply_stimulus(1'b0, 32'hA000_0100, 3'd3, 64'd0, 8'd0);
    next_cycle;
    next_cycle;
    next_cycle;
    check_output("rstR_c3_r_ready", r_ready, 1);
    rst = 1'b1;
    next_cycle;
    check_output("rstR_req_ready", req_ready, 1);
    check_output("rstR_r_ready", r_ready, 0);
    check_output("rstR_resp", {resp_valid, resp_err}, 0);
    rst = 1'b0;
    resp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle;
      if (resp_valid) resp_seen = 1;
    end
    check_output("rstR_no_resp", resp_seen, 0);

    // AR never accepted.
    ar_ready = 1'b0;
    apply_stimulus(1'b0, 32'hA000_0000, 3'd3, 64'd0, 8'd0);
    ar_cnt = 0; resp_seen = 0; err_seen = 0;
`ifdef DCACHE_UNCACHE_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      next_cycle;
      if (ar_valid) ar_cnt++;
      if (resp_valid) begin
        resp_seen = 1;
        err_seen  = resp_err;
      end
    end
    check_output("to_ar_cycles", ar_cnt, 16);
    check_output("to_resp_seen", resp_seen, 1);
    check_output("to_resp_err", err_seen, 1);
    check_output("to_idle", {req_ready, ar_valid}, 2'b10);
`else
    for (int i = 0; i < 1000; i++) begin
      next_cycle;
      if (resp_valid) resp_seen = 1;
    end
    check_output("noto_ar_valid", ar_valid, 1);
    check_output("noto_no_resp", resp_seen, 0);
    rst = 1'b1;
    next_cycle;
    rst = 1'b0;
    check_output("noto_reset_idle", {req_ready, ar_valid}, 2'b10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
